bus_arbiter_2m: RTL

//  Two-master bus arbiter that owns the select line of the shared 2:1 bus mux
//  (sel=0 routes master 0, sel=1 routes master 1). It samples request lines,

---
 rtl/bus_arbiter_2m.sv | 126 ++++++++++++
 1 files changed

// File: rtl/bus_arbiter_2m.sv
// Two-master bus arbiter with registered one-hot grants, mux select and hold-limited tenure.
// Define ROUND_ROBIN_EN for round-robin tie-break from idle; default build uses fixed M0 priority.
module bus_arbiter_2m #(
    parameter int unsigned MAX_HOLD = 4,
    parameter int unsigned CNT_W    = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic m0_req,
    input  logic m1_req,
    output logic m0_grant,
    output logic m1_grant,
    output logic sel,
    output logic busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_M0   = 2'd1,
        S_M1   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   hold_q, hold_d;
    logic               sel_q, sel_d;
    logic               m0_grant_q, m1_grant_q, busy_q;
`ifdef ROUND_ROBIN_EN
    logic               last_q, last_d;
`endif

    // Next-state, hold counter, select and owner history
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        sel_d   = sel_q;
`ifdef ROUND_ROBIN_EN
        last_d  = last_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (m0_req && m1_req) begin
`ifdef ROUND_ROBIN_EN
                    state_d = last_q ? S_M0 : S_M1;
`else
                    state_d = S_M0;
`endif
                end else if (m0_req) begin
                    state_d = S_M0;
                end else if (m1_req) begin
                    state_d = S_M1;
                end
            end
            S_M0: begin
                if (!m0_req) begin
                    state_d = m1_req ? S_M1 : S_IDLE;
                end else if (m1_req && (hold_q == HOLD_LAST)) begin
                    state_d = S_M1;
                end
            end
            S_M1: begin
                if (!m1_req) begin
                    state_d = m0_req ? S_M0 : S_IDLE;
                end else if (m0_req && (hold_q == HOLD_LAST)) begin
                    state_d = S_M0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Counter measures the current tenure and saturates rather than wrapping
        if ((state_d != state_q) || (state_d == S_IDLE)) begin
            hold_d = '0;
        end else if (hold_q != HOLD_LAST) begin
            hold_d = hold_q + CNT_W'(1);
        end

        if (state_d == S_M0) begin
            sel_d = 1'b0;
        end else if (state_d == S_M1) begin
            sel_d = 1'b1;
        end

`ifdef ROUND_ROBIN_EN
        if (state_d != state_q) begin
            if (state_d == S_M0) begin
                last_d = 1'b0;
            end else if (state_d == S_M1) begin
                last_d = 1'b1;
            end
        end
`endif
    end

    // All state and outputs registered; reset drops grants immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            hold_q     <= '0;
            sel_q      <= 1'b0;
            m0_grant_q <= 1'b0;
            m1_grant_q <= 1'b0;
            busy_q     <= 1'b0;
`ifdef ROUND_ROBIN_EN
            last_q     <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            sel_q      <= sel_d;
            m0_grant_q <= (state_d == S_M0);
            m1_grant_q <= (state_d == S_M1);
            busy_q     <= (state_d != S_IDLE);
`ifdef ROUND_ROBIN_EN
            last_q     <= last_d;
`endif
        end
    end

    assign m0_grant = m0_grant_q;
    assign m1_grant = m1_grant_q;
    assign sel      = sel_q;
    assign busy     = busy_q;

endmodule
